// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch queue entry type.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries with a single-cycle flush.
// The head entry is visible on the output in the cycle after it is pushed.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch.sv
// Fetch stage: sequential PC generation, credit-limited in-order imem requests,
// and a show-ahead instruction queue presented to decode.
module fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              QDEPTH    = 4,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ftch_imem_req,
    output logic [XLEN-1:0] ftch_imem_addr,
    input  logic            imem_ftch_gnt,
    input  logic            imem_ftch_rvalid,
    input  logic [XLEN-1:0] imem_ftch_rdata,
    input  logic            exec_ftch_redirect,
    input  logic [XLEN-1:0] exec_ftch_target,
    input  logic            dec_ftch_stall,
    output logic            ftch_dec_valid,
    output logic [XLEN-1:0] ftch_dec_instr,
    output logic [XLEN-1:0] ftch_dec_pc
);

    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int QCW = $clog2(QDEPTH + 1);
    localparam int SCW = $clog2(MAX_OUTST + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic            imem_req;
    logic            grant;
    logic            resp_drop;
    logic            resp_take;
    int              in_flight;
    int              queued;

    logic            q_push, q_pop, q_flush;
    fetch_entry_t    q_push_data, q_head;
    logic [QCW-1:0]  q_count;
    logic            q_full, q_empty;

    logic            s_push, s_pop, s_flush;
    fetch_entry_t    s_push_data, s_head;
    logic [SCW-1:0]  s_count;
    logic            s_full, s_empty;
    logic            unused_shadow;

    // Credit check: every granted request must be guaranteed a free queue slot when it returns.
    always_comb begin
        in_flight = int'(outst_q) + int'(drop_q);
        queued    = int'(q_count) + int'(outst_q);
        imem_req  = !rst && !exec_ftch_redirect && !q_full &&
                    (in_flight < MAX_OUTST) && (queued < QDEPTH);
    end

    assign grant     = imem_req && imem_ftch_gnt;
    assign resp_drop = imem_ftch_rvalid && (drop_q != '0);
    assign resp_take = imem_ftch_rvalid && (drop_q == '0) && !s_empty;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        q_flush = 1'b0;
        q_push  = 1'b0;
        q_pop   = 1'b0;
        s_flush = 1'b0;
        s_push  = 1'b0;
        s_pop   = 1'b0;
        if (exec_ftch_redirect) begin
            pc_d    = {exec_ftch_target[XLEN-1:2], 2'b00};
            outst_d = '0;
            // Everything still in flight turns into a drop, less the response landing right now.
            drop_d  = drop_q + outst_q - OW'(resp_drop || resp_take);
            q_flush = 1'b1;
            s_flush = 1'b1;
        end else begin
            if (grant) begin
                pc_d = pc_q + XLEN'(4);
            end
            outst_d = outst_q + OW'(grant) - OW'(resp_take);
            drop_d  = drop_q - OW'(resp_drop);
            q_push  = resp_take;
            q_pop   = ftch_dec_valid && !dec_ftch_stall;
            s_push  = grant;
            s_pop   = resp_take;
        end
    end

    assign q_push_data = '{pc: s_head.pc, instr: imem_ftch_rdata};
    assign s_push_data = '{pc: pc_q, instr: NOP_INSTR};

    fetch_fifo #(.DEPTH(QDEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (q_flush),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    fetch_fifo #(.DEPTH(MAX_OUTST)) u_pc_shadow (
        .clk       (clk),
        .rst       (rst),
        .push      (s_push),
        .push_data (s_push_data),
        .pop       (s_pop),
        .flush     (s_flush),
        .head      (s_head),
        .count     (s_count),
        .full      (s_full),
        .empty     (s_empty)
    );

    assign unused_shadow = ^{s_head.instr, s_count, s_full};

    assign ftch_imem_req  = imem_req;
    assign ftch_imem_addr = pc_q;
    assign ftch_dec_valid = !q_empty;
    assign ftch_dec_instr = q_empty ? NOP_INSTR : q_head.instr;
    assign ftch_dec_pc    = q_empty ? '0 : q_head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage, checked every cycle against a queue model
// of in-flight requests and the decode-facing instruction buffer.
module tb_fetch;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          QDEPTH    = 4;
    localparam int          MAX_OUTST = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } flight_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ftch_imem_req;
    logic [31:0] ftch_imem_addr;
    logic        imem_ftch_gnt = 1'b0;
    logic        imem_ftch_rvalid = 1'b0;
    logic [31:0] imem_ftch_rdata = 32'h0;
    logic        exec_ftch_redirect = 1'b0;
    logic [31:0] exec_ftch_target = 32'h0;
    logic        dec_ftch_stall = 1'b0;
    logic        ftch_dec_valid;
    logic [31:0] ftch_dec_instr;
    logic [31:0] ftch_dec_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int m_strays = 0;

    logic [31:0]  pend[$];
    bit           resp_hold = 1'b0;

    fetch_entry_t m_fifo[$];
    flight_t      m_flight[$];
    logic [31:0]  m_pc = RESET_PC;
    logic [31:0]  m_popped[$];

    fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST)) dut (
        .clk                (clk),
        .rst                (rst),
        .ftch_imem_req      (ftch_imem_req),
        .ftch_imem_addr     (ftch_imem_addr),
        .imem_ftch_gnt      (imem_ftch_gnt),
        .imem_ftch_rvalid   (imem_ftch_rvalid),
        .imem_ftch_rdata    (imem_ftch_rdata),
        .exec_ftch_redirect (exec_ftch_redirect),
        .exec_ftch_target   (exec_ftch_target),
        .dec_ftch_stall     (dec_ftch_stall),
        .ftch_dec_valid     (ftch_dec_valid),
        .ftch_dec_instr     (ftch_dec_instr),
        .ftch_dec_pc        (ftch_dec_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic gnt,
                                 input logic redir, input logic [31:0] tgt);
        dec_ftch_stall     = stall;
        imem_ftch_gnt      = gnt;
        exec_ftch_redirect = redir;
        exec_ftch_target   = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!ftch_dec_valid && n < 40) begin
            tick();
            #1;
            n++;
        end
        if (!ftch_dec_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // In-order memory with a one-cycle response; pending requests survive reset.
    always begin
        @(posedge clk);
        #1;
        if (!resp_hold && pend.size() > 0) begin
            imem_ftch_rvalid = 1'b1;
            imem_ftch_rdata  = mem_word(pend.pop_front());
        end else begin
            imem_ftch_rvalid = 1'b0;
            imem_ftch_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        if (!rst && ftch_imem_req && imem_ftch_gnt) pend.push_back(ftch_imem_addr);
    end

    // Model: in-flight requests in order, the oldest ones marked stale by a redirect.
    always @(negedge clk) begin
        int           live;
        int           n;
        logic         exp_req;
        logic         do_pop;
        logic         take;
        flight_t      f;
        fetch_entry_t e;
        if (rst) begin
            checkOutput("rst_req",   32'(ftch_imem_req),  32'd0);
            checkOutput("rst_addr",  ftch_imem_addr,      RESET_PC);
            checkOutput("rst_valid", 32'(ftch_dec_valid), 32'd0);
            checkOutput("rst_instr", ftch_dec_instr,      NOP_INSTR);
            checkOutput("rst_pc",    ftch_dec_pc,         32'd0);
            m_fifo.delete();
            m_flight.delete();
            m_pc = RESET_PC;
        end else begin
            live = 0;
            foreach (m_flight[i]) if (!m_flight[i].stale) live++;
            exp_req = !exec_ftch_redirect && (m_flight.size() < MAX_OUTST) &&
                      (m_fifo.size() + live < QDEPTH);
            checkOutput("req",  32'(ftch_imem_req), 32'(exp_req));
            checkOutput("addr", ftch_imem_addr,     m_pc);
            if (m_fifo.size() > 0) begin
                checkOutput("valid", 32'(ftch_dec_valid), 32'd1);
                checkOutput("instr", ftch_dec_instr,      m_fifo[0].instr);
                checkOutput("pc",    ftch_dec_pc,         m_fifo[0].pc);
            end else begin
                checkOutput("valid", 32'(ftch_dec_valid), 32'd0);
                checkOutput("instr", ftch_dec_instr,      NOP_INSTR);
                checkOutput("pc",    ftch_dec_pc,         32'd0);
            end
            do_pop = (m_fifo.size() > 0) && !dec_ftch_stall;
            take   = 1'b0;
            if (imem_ftch_rvalid) begin
                if (m_flight.size() == 0) begin
                    m_strays++;
                    $display("[TB] note: rvalid with nothing in flight ignored at %0t", $time);
                end else begin
                    f = m_flight.pop_front();
                    if (!f.stale && !exec_ftch_redirect) begin
                        take    = 1'b1;
                        e.pc    = f.pc;
                        e.instr = imem_ftch_rdata;
                    end
                end
            end
            if (exec_ftch_redirect) begin
                m_fifo.delete();
                n = m_flight.size();
                for (int i = 0; i < n; i++) begin
                    f = m_flight.pop_front();
                    f.stale = 1'b1;
                    m_flight.push_back(f);
                end
                m_pc = {exec_ftch_target[31:2], 2'b00};
            end else begin
                if (do_pop) begin
                    m_popped.push_back(m_fifo[0].pc);
                    void'(m_fifo.pop_front());
                end
                if (take) m_fifo.push_back(e);
                if (exp_req && imem_ftch_gnt) begin
                    f.pc    = m_pc;
                    f.stale = 1'b0;
                    m_flight.push_back(f);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1 rst = 1'b1;
        repeat (3) tick();

        // Straight-line fetch: decode sees 0,4,8,C from cycle 2 after release.
        rst = 1'b0;
        #1 checkOutput("c0_valid", 32'(ftch_dec_valid), 32'd0);
        tick();
        #1 checkOutput("c1_valid", 32'(ftch_dec_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checkOutput("line_valid", 32'(ftch_dec_valid), 32'd1);
            checkOutput("line_pc",    ftch_dec_pc,         32'(4 * i));
            checkOutput("line_instr", ftch_dec_instr,      mem_word(32'(4 * i)));
        end

        // Stall six cycles: head holds at 0xC and requests stop once the queue is committed.
        dec_ftch_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            checkOutput("stall_pc",    ftch_dec_pc,         32'h0000_000C);
            checkOutput("stall_valid", 32'(ftch_dec_valid), 32'd1);
        end
        checkOutput("stall_req", 32'(ftch_imem_req), 32'd0);
        dec_ftch_stall = 1'b0;
        repeat (8) tick();
        checkOutput("popped_min", 32'(m_popped.size() >= 8), 32'd1);
        foreach (m_popped[i]) checkOutput("popped_seq", m_popped[i], 32'(4 * i));

        // Redirect with two requests held in flight, stall asserted at the same time.
        resp_hold = 1'b1;
        repeat (3) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        #1 checkOutput("redir_req", 32'(ftch_imem_req), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        resp_hold = 1'b0;
        #1 checkOutput("post_redir_valid", 32'(ftch_dec_valid), 32'd0);
        waitValid("redir");
        checkOutput("redir_pc",    ftch_dec_pc,    32'h0000_0100);
        checkOutput("redir_instr", ftch_dec_instr, mem_word(32'h0000_0100));

        // Grant withheld three cycles after jumping to 0x200.
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            #1 checkOutput("nogrant_addr", ftch_imem_addr, 32'h0000_0200);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        waitValid("nogrant");
        checkOutput("nogrant_pc0", ftch_dec_pc, 32'h0000_0200);
        tick();
        #1;
        checkOutput("nogrant_valid1", 32'(ftch_dec_valid), 32'd1);
        checkOutput("nogrant_pc1",    ftch_dec_pc,         32'h0000_0204);

        // Address wrap: low target bits are ignored and 0xFFFFFFFC is followed by 0.
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1 checkOutput("wrap_addr", ftch_imem_addr, 32'hFFFF_FFFC);
        waitValid("wrap0");
        checkOutput("wrap_pc0",    ftch_dec_pc,    32'hFFFF_FFFC);
        checkOutput("wrap_instr0", ftch_dec_instr, mem_word(32'hFFFF_FFFC));
        tick();
        #1;
        waitValid("wrap1");
        checkOutput("wrap_pc1",    ftch_dec_pc,    32'h0000_0000);
        checkOutput("wrap_instr1", ftch_dec_instr, mem_word(32'h0000_0000));

        // Async reset mid-stream with two responses pending in memory.
        repeat (8) tick();
        resp_hold = 1'b1;
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("arst_req",   32'(ftch_imem_req),  32'd0);
        checkOutput("arst_addr",  ftch_imem_addr,      RESET_PC);
        checkOutput("arst_valid", 32'(ftch_dec_valid), 32'd0);
        checkOutput("arst_instr", ftch_dec_instr,      NOP_INSTR);
        checkOutput("arst_pc",    ftch_dec_pc,         32'd0);
        tick();
        tick();
        rst = 1'b0;
        resp_hold = 1'b0;
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        waitValid("restart");
        checkOutput("restart_pc",    ftch_dec_pc,    RESET_PC);
        checkOutput("restart_instr", ftch_dec_instr, mem_word(RESET_PC));
        checkOutput("stray_rvalids", 32'(m_strays),  32'd2);

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
First CPU pipeline stage, directly upstream of decode. Generates sequential PCs and issues in-order requests to the instruction memory/L1 icache port. Buffers returned instructions in a small FIFO and presents them to decode as ftch_dec_instr / ftch_dec_pc with a valid/stall handshake. Handles redirects from execute (jumps and taken branches) by flushing queued instructions and discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
QDEPTH, 4, instruction FIFO depth in entries (power of two, at least 2)
MAX_OUTST, 2, maximum accepted imem requests still awaiting a response

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
ftch_imem_req  out  1  request valid
ftch_imem_addr  out  32  word-aligned fetch address
imem_ftch_gnt  in  1  request accepted this cycle when req is high
imem_ftch_rvalid  in  1  response valid; responses return in request order
imem_ftch_rdata  in  32  instruction word of the response
exec_ftch_redirect  in  1  redirect pulse
exec_ftch_target  in  32  redirect PC; bits [1:0] are ignored and treated as 0
dec_ftch_stall  in  1  decode cannot accept an instruction this cycle
ftch_dec_valid  out  1  instruction/PC pair on the outputs is valid
ftch_dec_instr  out  32  instruction word; NOP 32'h0000_0013 when not valid
ftch_dec_pc  out  32  PC of ftch_dec_instr; 0 when not valid

Behaviour:
- Reset (asynchronous, can occur mid-operation): pc=RESET_PC, FIFO empty, outstanding=0, drop=0. Outputs: ftch_imem_req=0, ftch_imem_addr=RESET_PC, ftch_dec_valid=0, ftch_dec_instr=NOP, ftch_dec_pc=0.
- Credit rule: ftch_imem_req = !redirect && (outstanding + drop) < MAX_OUTST && (fifo_count + outstanding) < QDEPTH. This guarantees every returned response has a free FIFO slot.
- ftch_imem_addr = pc (combinational from the pc register). On req && gnt: pc <= pc+4 (wraps modulo 2^32), outstanding += 1.
- Responses: on rvalid, if drop>0 then drop -= 1 and the data is discarded. Otherwise the entry {pc_tag, rdata} is pushed and outstanding -= 1.
- pc_tag is taken from a request-PC shadow queue (MAX_OUTST deep) written at grant.
- A grant and a response in the same cycle update the counters net (outstanding unchanged).
- Output latency: a response accepted at cycle N appears on ftch_dec_* at N+1 (registered FIFO, show-ahead). Best-case request-to-decode latency is 2 cycles for a memory with 1-cycle response.
- Dequeue happens when ftch_dec_valid && !dec_ftch_stall. While stalled, the outputs hold stable.
- Redirect at cycle N:
  - ftch_imem_req is forced 0 in cycle N.
  - pc <= {target[31:2],2'b00}.
  - The FIFO and shadow queue are flushed.
  - drop <= outstanding minus any non-dropped response arriving at N. Responses arriving at N are discarded regardless.
  - outstanding <= 0.
  - ftch_dec_valid=0 from N+1. The first request to the target is issued at N+1.
- Redirect and stall together: the redirect wins; the FIFO is flushed.
- FIFO full: no new request is issued (credit rule). FIFO empty: ftch_dec_valid=0.
- Push and pop in the same cycle on a full FIFO is legal: count is unchanged.
- An rvalid with outstanding=0 and drop=0 is a protocol error and is ignored. The bench flags it with an assertion.

Decomposition:
- cpu_pkg holds: XLEN=32, NOP_INSTR=32'h0000_0013, and a fetch_entry_t packed struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty, and show-ahead head output. It is reused for the shadow PC queue with instr unused.
- Top level fetch contains the PC register, the outstanding/drop counters, and the request/credit logic.

Test Plan:
- Straight-line fetch with a 1-cycle memory, always granting, from RESET_PC=0 -> decode sees PCs 0,4,8,C on consecutive cycles starting at cycle 2 after reset release, with instr equal to the memory words.
- dec_ftch_stall held for 6 cycles -> outputs are held stable, requests stop once FIFO plus outstanding reach QDEPTH=4, and no instruction is lost or duplicated after release.
- Redirect to 32'h0000_0103 with 2 requests outstanding -> both late responses are dropped, the next valid output has pc=32'h100, and ftch_dec_valid=0 in the cycle after the redirect.
- Grant withheld (gnt=0) for 3 cycles -> ftch_imem_addr stays constant at the same PC and fetch resumes in order after the grant.
- Async reset asserted mid-stream with a response pending -> all outputs return to their reset values immediately; after release, fetch restarts at RESET_PC and the stale rvalid is ignored.
- PC at 32'hFFFF_FFFC -> the next fetch address wraps to 32'h0000_0000.
